// File: rtl/rtl_adder_pipe.sv
// rtl_adder_pipe -- chunked carry-pipelined adder with valid/ready flow control.
//
// Computes {co, sum} = a + b + ci over WIDTH bits, CHUNK bits per register
// stage (NSTAGES = WIDTH / CHUNK). Stage k adds operand chunk k using the carry
// registered by stage k-1. Completed low result chunks and not-yet-used high
// operand chunks travel along with the carry in per-stage skew registers.
//
// Optional feature: define RTL_ADDER_PIPE_OVF_EN to add the signed-overflow
// output ovf. Without the macro the port and its logic are absent.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   a/b/ci hold a valid operand set
//   in_ready   out  operands accepted this cycle (combinational = advance)
//   a, b       in   WIDTH-bit unsigned addends
//   ci         in   carry-in
//   out_valid  out  sum/co(/ovf) hold a valid result
//   out_ready  in   consumer takes the result this cycle
//   sum        out  WIDTH-bit result
//   co         out  carry-out
//   ovf        out  signed overflow (only with RTL_ADDER_PIPE_OVF_EN)
module rtl_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co
`ifdef RTL_ADDER_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Guarded divisor keeps elaboration alive long enough to report a bad CHUNK.
  localparam int CHUNK_SAFE = (CHUNK >= 1) ? CHUNK : 1;
  localparam int NSTAGES    = ((WIDTH / CHUNK_SAFE) >= 1) ? (WIDTH / CHUNK_SAFE) : 1;

  generate
    if ((CHUNK < 1) || ((WIDTH % CHUNK_SAFE) != 0)) begin : g_param_err
      $error("rtl_adder_pipe: CHUNK must be >= 1 and divide WIDTH");
    end
  endgenerate

  // Per-stage state: valid, carry out of the chunk just added, skewed operands
  // and the partially assembled result.
  logic             v_r [NSTAGES];
  logic             c_r [NSTAGES];
  logic [WIDTH-1:0] a_r [NSTAGES];
  logic [WIDTH-1:0] b_r [NSTAGES];
  logic [WIDTH-1:0] s_r [NSTAGES];

  // What each stage would load on an advancing edge.
  logic             v_src_s [NSTAGES];
  logic             c_src_s [NSTAGES];
  logic [WIDTH-1:0] a_src_s [NSTAGES];
  logic [WIDTH-1:0] b_src_s [NSTAGES];
  logic [WIDTH-1:0] s_src_s [NSTAGES];
  logic [WIDTH-1:0] s_nxt_s [NSTAGES];
  logic [CHUNK_SAFE:0] add_s [NSTAGES];

  logic advance_s;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign advance_s = !v_r[NSTAGES-1] || out_ready;
  assign in_ready  = advance_s;

  // Stage input selection and the per-stage chunk addition.
  always_comb begin
    v_src_s[0] = in_valid;
    c_src_s[0] = ci;
    a_src_s[0] = a;
    b_src_s[0] = b;
    s_src_s[0] = {WIDTH{1'b0}};
    for (int k = 1; k < NSTAGES; k++) begin
      v_src_s[k] = v_r[k-1];
      c_src_s[k] = c_r[k-1];
      a_src_s[k] = a_r[k-1];
      b_src_s[k] = b_r[k-1];
      s_src_s[k] = s_r[k-1];
    end
    for (int k = 0; k < NSTAGES; k++) begin
      add_s[k] = {1'b0, a_src_s[k][k*CHUNK_SAFE +: CHUNK_SAFE]}
               + {1'b0, b_src_s[k][k*CHUNK_SAFE +: CHUNK_SAFE]}
               + {{CHUNK_SAFE{1'b0}}, c_src_s[k]};
      s_nxt_s[k] = s_src_s[k];
      s_nxt_s[k][k*CHUNK_SAFE +: CHUNK_SAFE] = add_s[k][CHUNK_SAFE-1:0];
    end
  end

  // Stage registers; data only loads behind a valid so bubbles leave the
  // last real result untouched on the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSTAGES; k++) begin
        v_r[k] <= 1'b0;
        c_r[k] <= 1'b0;
        a_r[k] <= {WIDTH{1'b0}};
        b_r[k] <= {WIDTH{1'b0}};
        s_r[k] <= {WIDTH{1'b0}};
      end
    end else if (advance_s) begin
      for (int k = 0; k < NSTAGES; k++) begin
        v_r[k] <= v_src_s[k];
        if (v_src_s[k]) begin
          c_r[k] <= add_s[k][CHUNK_SAFE];
          a_r[k] <= a_src_s[k];
          b_r[k] <= b_src_s[k];
          s_r[k] <= s_nxt_s[k];
        end
      end
    end
  end

  assign out_valid = v_r[NSTAGES-1];
  assign sum       = s_r[NSTAGES-1];
  assign co        = c_r[NSTAGES-1];

`ifdef RTL_ADDER_PIPE_OVF_EN
  logic ovf_r;

  // Overflow is formed in the final stage, where the top sum bit first exists.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (advance_s && v_src_s[NSTAGES-1]) begin
      ovf_r <= (a_src_s[NSTAGES-1][WIDTH-1] == b_src_s[NSTAGES-1][WIDTH-1]) &&
               (s_nxt_s[NSTAGES-1][WIDTH-1] != a_src_s[NSTAGES-1][WIDTH-1]);
    end
  end

  assign ovf = ovf_r;
`endif

endmodule
